// File: rtl/fb_reader_pkg.sv
// Shared types and constants for the frame-buffer reader.
package fb_reader_pkg;

  // Controller states: IDLE waits for start, RUN issues reads, DRAIN empties the buffer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Capacity of the output buffer. Buffered words plus the in-flight read never exceed this.
  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/fb_reader_skid.sv
// Two-entry FIFO between the RAM read port and the pixel stream.
// Each entry holds one data word and the burst-last flag for that word.
// pop_i is ignored while the FIFO is empty. push_i must not be raised when the
// FIFO is full unless pop_i is also high; the controller keeps that guarantee.
module fb_reader_skid
  import fb_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  logic [WIDTH-1:0] data_q [BUF_DEPTH];
  logic             last_q [BUF_DEPTH];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic             pop_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign count_o = count_q;
  assign data_o  = data_q[rd_ptr_q];
  assign last_o  = last_q[rd_ptr_q];

  // Storage, pointers and occupancy; the head entry is held while not popped.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        data_q[wr_ptr_q] <= push_data_i;
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/fb_reader.sv
// Frame-buffer burst reader: reads count_i words from a synchronous RAM starting
// at base_addr_i and streams them out with a valid/ready handshake.
// Optional feature macro FB_READER_CONTINUOUS_EN: replays the latched burst
// forever (one done_o pulse per frame) until reset.
//
// Handshake: a word moves on pix_o when pix_valid_o && pix_ready_i at a rising
// edge; pix_valid_o never drops and pix_data_o/pix_last_o never change while a
// word is offered but not yet accepted.
module fb_reader
  import fb_reader_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 start_i,
  input  logic [ADDR_BITS-1:0] base_addr_i,
  input  logic [ADDR_BITS:0]   count_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 read_enable_o,
  output logic [ADDR_BITS-1:0] read_addr_o,
  input  logic [WIDTH-1:0]     read_data_i,
  output logic                 pix_valid_o,
  input  logic                 pix_ready_i,
  output logic [WIDTH-1:0]     pix_data_o,
  output logic                 pix_last_o
);

  localparam logic [ADDR_BITS:0]   REM_ONE  = 1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS:0]   remain_q, remain_d;
  logic                 inflight_q;
  logic                 inflight_last_q;
  logic                 done_q, done_d;
`ifdef FB_READER_CONTINUOUS_EN
  logic [ADDR_BITS-1:0] base_lat_q;
  logic [ADDR_BITS:0]   count_lat_q;
`endif

  logic [1:0] buf_count;
  logic       buf_last;
  logic       pop;
  logic [2:0] used;
  logic       room;
  logic       can_issue;
  logic       issue;
  logic       final_issue;

  // Occupancy after this cycle's pop must leave a slot for a new read.
  assign pop         = pix_valid_o && pix_ready_i;
  assign used        = {1'b0, buf_count} + {2'b00, inflight_q};
  assign room        = (used - {2'b00, pop}) <= 3'd1;
`ifdef FB_READER_CONTINUOUS_EN
  assign can_issue   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
`else
  assign can_issue   = (state_q == ST_RUN);
`endif
  assign issue       = can_issue && (remain_q != '0) && room;
  assign final_issue = issue && (remain_q == REM_ONE);

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign read_enable_o = issue;
  assign read_addr_o   = addr_q;
  assign pix_valid_o   = (buf_count != 2'd0);
  assign pix_last_o    = buf_last;

  fb_reader_skid #(.WIDTH(WIDTH)) u_skid (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .push_i      (inflight_q),
    .push_data_i (read_data_i),
    .push_last_i (inflight_last_q),
    .pop_i       (pop),
    .count_o     (buf_count),
    .data_o      (pix_data_o),
    .last_o      (buf_last)
  );

  // Next-state logic: burst start, read address/remaining update, completion pulse.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    if (issue) begin
      addr_d   = addr_q + ADDR_ONE;
      remain_d = remain_q - REM_ONE;
    end
    if (pop && buf_last) begin
      done_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (count_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = ST_RUN;
            addr_d   = base_addr_i;
            remain_d = count_i;
          end
        end
      end
      ST_RUN: begin
        if (final_issue) begin
          state_d = ST_DRAIN;
`ifdef FB_READER_CONTINUOUS_EN
          addr_d   = base_lat_q;
          remain_d = count_lat_q;
`endif
        end
      end
      ST_DRAIN: begin
`ifdef FB_READER_CONTINUOUS_EN
        // Counters were reloaded on the final issue, so reads keep flowing.
        if (final_issue) begin
          addr_d   = base_lat_q;
          remain_d = count_lat_q;
        end else begin
          state_d = ST_RUN;
        end
`else
        if (pop && buf_last) begin
          state_d = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and in-flight tracking of the one-cycle RAM latency.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= issue;
      inflight_last_q <= final_issue;
      done_q          <= done_d;
    end
  end

`ifdef FB_READER_CONTINUOUS_EN
  // Burst parameters kept for replaying every frame.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      base_lat_q  <= '0;
      count_lat_q <= '0;
    end else if (state_q == ST_IDLE && start_i) begin
      base_lat_q  <= base_addr_i;
      count_lat_q <= count_i;
    end
  end
`endif

endmodule

// File: tb/tb_fb_reader.sv
// Testbench for fb_reader: RAM model, scoreboard with expected word and address
// queues, negedge monitor, randomized ready patterns and burst parameters.
module tb_fb_reader;

  localparam int W  = 8;
  localparam int AB = 8;
`ifdef FB_READER_CONTINUOUS_EN
  localparam logic BUSY_AT_DONE = 1'b1;
`else
  localparam logic BUSY_AT_DONE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk = ~clk;

  logic          start_i = 1'b0;
  logic [AB-1:0] base_addr_i = '0;
  logic [AB:0]   count_i = '0;
  logic          busy_o, done_o, read_enable_o;
  logic [AB-1:0] read_addr_o;
  logic [W-1:0]  read_data_i;
  logic          pix_valid_o;
  logic          pix_ready_i = 1'b0;
  logic [W-1:0]  pix_data_o;
  logic          pix_last_o;

  fb_reader #(.WIDTH(W), .ADDR_BITS(AB)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .count_i(count_i), .busy_o(busy_o), .done_o(done_o), .read_enable_o(read_enable_o),
    .read_addr_o(read_addr_o), .read_data_i(read_data_i), .pix_valid_o(pix_valid_o),
    .pix_ready_i(pix_ready_i), .pix_data_o(pix_data_o), .pix_last_o(pix_last_o)
  );

  // RAM model: data valid exactly one cycle after the read strobe.
  logic [W-1:0] ram [256];
  always @(posedge clk) if (read_enable_o) read_data_i <= ram[read_addr_o];

  // ---------------- scoreboard ----------------
  logic [W:0]    exp_q[$];
  logic [AB-1:0] exp_addr_q[$];
  int            hs_cyc_q[$];
  int n_cmp = 0, n_fail = 0;
  int issued = 0, accepted = 0, cyc = 0;
  bit done_pend = 0, stall_prev = 0;
  logic [W:0] stall_word, e;
  int ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ready pattern generator
  initial forever begin
    @(posedge clk); #2;
    case (ready_mode)
      0: pix_ready_i = 1'b1;
      1: pix_ready_i = ~pix_ready_i;
      2: pix_ready_i = ($urandom_range(0, 3) != 0);
      default: pix_ready_i = 1'b0;
    endcase
  end

  // monitor: sampled on the falling edge
  always @(negedge clk) if (reset_ni) begin
    cyc++;
    if (done_pend || done_o) begin
      check("done_o", done_o, done_pend);
      if (done_pend) check("busy_at_done", busy_o, BUSY_AT_DONE);
    end
    done_pend = 1'b0;
    if (start_i && count_i == 0) done_pend = 1'b1;
    if (read_enable_o) begin
      issued++;
      if (exp_addr_q.size() == 0) check("unexpected_read", 1, 0);
      else check("read_addr", read_addr_o, exp_addr_q.pop_front());
    end
    if (stall_prev) begin
      check("stall_valid", pix_valid_o, 1);
      check("stall_stable", {pix_last_o, pix_data_o}, stall_word);
    end
    if (pix_valid_o && pix_ready_i) begin
      accepted++;
      hs_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_word", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("pix_word", {pix_last_o, pix_data_o}, e);
        if (e[W]) done_pend = 1'b1;
      end
    end
    check("outstanding_le2", (issued - accepted <= 2), 1);
    stall_prev = pix_valid_o && !pix_ready_i;
    stall_word = {pix_last_o, pix_data_o};
  end

  // ---------------- driver tasks ----------------
  task automatic expect_burst(input logic [AB-1:0] base, input int cnt, input int n_addr_frames,
                              input int n_word_frames);
    logic [AB-1:0] a;
    for (int f = 0; f < n_addr_frames; f++)
      for (int i = 0; i < cnt; i++) begin
        a = base + AB'(i);
        exp_addr_q.push_back(a);
        if (f < n_word_frames) exp_q.push_back({(i == cnt - 1), ram[a]});
      end
  endtask

  task automatic start_burst(input logic [AB-1:0] base, input int cnt);
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = base; count_i = (AB+1)'(cnt);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 3000) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_timeout"}, (t < 3000), 1);
    check({name, "_addr_left"}, exp_addr_q.size(), 0);
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    #1;
    check("rst_busy", busy_o, 0);       check("rst_done", done_o, 0);
    check("rst_re", read_enable_o, 0);  check("rst_valid", pix_valid_o, 0);
    check("rst_last", pix_last_o, 0);   check("rst_addr", read_addr_o, 0);
    check("rst_data", pix_data_o, 0);
    exp_q.delete(); exp_addr_q.delete(); hs_cyc_q.delete();
    issued = 0; accepted = 0; done_pend = 0; stall_prev = 0;
    @(posedge clk); #1;
    reset_ni = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    logic [AB-1:0] rb;
    int rc;
    for (int i = 0; i < 256; i++) ram[i] = W'($urandom_range(0, 255));
    repeat (2) @(posedge clk);
    #1;
    do_reset();

`ifdef FB_READER_CONTINUOUS_EN
    // frames of 3 words repeat back to back
    ready_mode = 0;
    expect_burst(8'h20, 3, 3, 2);
    start_burst(8'h20, 3);
    t = 0;
    while (accepted < 6 && t < 200) begin @(posedge clk); t++; end
    #1; ready_mode = 3;
    check("cont_timeout", (t < 200), 1);
    check("cont_no_gap", hs_cyc_q[5] - hs_cyc_q[0], 5);
    repeat (10) @(posedge clk);
    #1; check("cont_busy", busy_o, 1);
    do_reset();
`else
    // base 0x10, count 4, ready high: consecutive words
    ready_mode = 0;
    hs_cyc_q.delete();
    expect_burst(8'h10, 4, 1, 1);
    start_burst(8'h10, 4);
    wait_idle("b10");
    check("b10_words", hs_cyc_q.size(), 4);
    if (hs_cyc_q.size() == 4) check("b10_consecutive", hs_cyc_q[3] - hs_cyc_q[0], 3);

    // address wrap
    expect_burst(8'hFE, 4, 1, 1);
    start_burst(8'hFE, 4);
    wait_idle("wrap");

    // ready toggling each cycle
    ready_mode = 1;
    rb = AB'($urandom_range(0, 255));
    expect_burst(rb, 8, 1, 1);
    start_burst(rb, 8);
    wait_idle("toggle");

    // zero count: no reads, done next cycle, never busy
    ready_mode = 0;
    start_burst(8'h33, 0);
    check("zero_busy", busy_o, 0);
    wait_idle("zero");

    // reset after three of eight words, then a fresh burst
    expect_burst(8'h40, 8, 1, 1);
    start_burst(8'h40, 8);
    t = 0;
    while (accepted < 3 && t < 100) begin @(posedge clk); t++; end
    #1;
    check("mid_rst_timeout", (t < 100), 1);
    do_reset();
    expect_burst(8'h00, 2, 1, 1);
    start_burst(8'h00, 2);
    wait_idle("after_rst");

    // randomized bursts with random backpressure
    ready_mode = 2;
    for (int k = 0; k < 8; k++) begin
      rb = AB'($urandom_range(0, 255));
      rc = (k == 7) ? 256 : $urandom_range(1, 20);
      expect_burst(rb, rc, 1, 1);
      start_burst(rb, rc);
      wait_idle("rand");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
